// File: rtl/top_level.sv
// Pattern-count engine: scans core[128..159] for a 5-bit pattern and writes
// in-byte match count, matching-byte count and bit-string match count to core[192..194].

module data_mem (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);
    logic [7:0] core [0:255];

    // Single write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) core[addr] <= wdata;
    end

    assign rdata = core[addr];
endmodule

module reg_file (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata,
    input  logic [1:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] registers [0:3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) registers[i] <= '0;
        end else if (we) begin
            registers[waddr] <= wdata;
        end
    end

    assign rdata = registers[raddr];
endmodule

module datapath (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr_c,
    input  logic       mem_we_c,
    input  logic [1:0] wsel_c,
    input  logic       clr_c,
    input  logic       load_p_c,
    input  logic       shift_c,
    input  logic       count_en_c,
    input  logic       cross_en_c
);
    localparam int unsigned CNT_W = 8;

    logic [7:0]       rdata;
    logic [7:0]       pat;
    logic [7:0]       prev;
    logic [15:0]      pair;
    logic [2:0]       in_cnt;
    logic [2:0]       x_cnt;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [CNT_W-1:0] cnt_c;
    logic [7:0]       wr_data_c;

    data_mem dm (
        .clk   (clk),
        .we    (mem_we_c),
        .addr  (addr_c),
        .wdata (wr_data_c),
        .rdata (rdata)
    );

    // Register 0 holds the zero-extended pattern for the whole run.
    reg_file rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (load_p_c),
        .waddr (2'd0),
        .wdata ({3'b000, rdata[7:3]}),
        .raddr (2'd0),
        .rdata (pat)
    );

    // Windows 0..3 lie inside the previous byte; 4..7 straddle into the current one.
    always_comb begin
        pair   = {prev, rdata};
        in_cnt = '0;
        x_cnt  = '0;
        for (int k = 0; k < 4; k++) begin
            if ({3'b000, pair[15-k -: 5]} == pat) in_cnt = in_cnt + 3'd1;
        end
        for (int k = 4; k < 8; k++) begin
            if (cross_en_c && ({3'b000, pair[15-k -: 5]} == pat)) x_cnt = x_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev  <= '0;
            cnt_a <= '0;
            cnt_b <= '0;
            cnt_c <= '0;
        end else begin
            if (shift_c) prev <= rdata;
            if (clr_c) begin
                cnt_a <= '0;
                cnt_b <= '0;
                cnt_c <= '0;
            end else if (count_en_c) begin
                cnt_a <= cnt_a + CNT_W'(in_cnt);
                cnt_b <= cnt_b + CNT_W'(in_cnt != 3'd0);
                cnt_c <= cnt_c + CNT_W'(in_cnt) + CNT_W'(x_cnt);
            end
        end
    end

    always_comb begin
        case (wsel_c)
            2'd0:    wr_data_c = cnt_a;
            2'd1:    wr_data_c = cnt_b;
            default: wr_data_c = cnt_c;
        endcase
    end
endmodule

module top_level (
    input  logic CLK,
    input  logic RESET_N,
    input  logic START,
    output logic DONE
);
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned LAST_IDX = 32;

    typedef enum logic [2:0] {IDLE, LOAD, SCAN, WRITE, FINISH} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             done_nxt;
    logic             start_q;
    logic             start_fall_c;
    logic [7:0]       addr_c;
    logic             mem_we_c;
    logic [1:0]       wsel_c;
    logic             clr_c;
    logic             load_p_c;
    logic             shift_c;
    logic             count_en_c;
    logic             cross_en_c;

    assign start_fall_c = start_q & ~START;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state   <= IDLE;
            idx     <= '0;
            DONE    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            DONE    <= done_nxt;
            start_q <= START;
        end
    end

    // SCAN runs idx 0..32: idx 0 primes prev, idx 32 finishes byte 31 without crossing windows.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        done_nxt   = DONE;
        addr_c     = 8'd160;
        mem_we_c   = 1'b0;
        wsel_c     = 2'd0;
        clr_c      = 1'b0;
        load_p_c   = 1'b0;
        shift_c    = 1'b0;
        count_en_c = 1'b0;
        cross_en_c = 1'b0;
        case (state)
            IDLE: begin
                if (start_fall_c) begin
                    state_nxt = LOAD;
                    done_nxt  = 1'b0;
                end
            end
            LOAD: begin
                addr_c    = 8'd160;
                load_p_c  = 1'b1;
                clr_c     = 1'b1;
                idx_nxt   = '0;
                state_nxt = SCAN;
            end
            SCAN: begin
                addr_c     = 8'd128 + 8'(idx);
                shift_c    = (idx != IDX_W'(LAST_IDX));
                count_en_c = (idx != '0);
                cross_en_c = (idx != '0) && (idx != IDX_W'(LAST_IDX));
                if (idx == IDX_W'(LAST_IDX)) begin
                    idx_nxt   = '0;
                    state_nxt = WRITE;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            WRITE: begin
                addr_c   = 8'd192 + 8'(idx);
                mem_we_c = 1'b1;
                wsel_c   = idx[1:0];
                if (idx == IDX_W'(2)) begin
                    idx_nxt   = '0;
                    state_nxt = FINISH;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            FINISH: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    datapath dp (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .addr_c     (addr_c),
        .mem_we_c   (mem_we_c),
        .wsel_c     (wsel_c),
        .clr_c      (clr_c),
        .load_p_c   (load_p_c),
        .shift_c    (shift_c),
        .count_en_c (count_en_c),
        .cross_en_c (cross_en_c)
    );
endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: backdoor-loads core, runs the engine, checks results.

module tb_top_level;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic done;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    top_level dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .START   (start),
        .DONE    (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_data(input logic [4:0] p, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] rest);
        dut.dp.dm.core[128] = b0;
        dut.dp.dm.core[129] = b1;
        for (int i = 130; i < 160; i++) dut.dp.dm.core[i] = rest;
        dut.dp.dm.core[160] = {p, 3'b101};
    endtask

    task automatic check_untouched(input string tag);
        check({tag, "_c6"},   32'(dut.dp.dm.core[6]),   32'h11);
        check({tag, "_c7"},   32'(dut.dp.dm.core[7]),   32'h22);
        check({tag, "_c8"},   32'(dut.dp.dm.core[8]),   32'h33);
        check({tag, "_c191"}, 32'(dut.dp.dm.core[191]), 32'h5A);
        check({tag, "_c195"}, 32'(dut.dp.dm.core[195]), 32'hA5);
    endtask

    // Data is loaded while START is high, then START falls to begin the run.
    task automatic run(input string tag, input logic [4:0] p, input logic [7:0] b0,
                       input logic [7:0] b1, input logic [7:0] rest,
                       input int ea, input int eb, input int ec, input int pulse_at);
        int n;
        @(negedge clk) start = 1'b1;
        load_data(p, b0, b1, rest);
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        check({tag, "_done_fall"}, 32'(done), 32'd0);
        n = 0;
        while (!done && n < 128) begin
            @(negedge clk);
            n++;
            start = (n == pulse_at);
        end
        start = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(n <= 40), 32'd1);
        check({tag, "_a"}, 32'(dut.dp.dm.core[192]), 32'(ea));
        check({tag, "_b"}, 32'(dut.dp.dm.core[193]), 32'(eb));
        check({tag, "_c"}, 32'(dut.dp.dm.core[194]), 32'(ec));
        check_untouched(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        dut.dp.dm.core[6]   = 8'h11;
        dut.dp.dm.core[7]   = 8'h22;
        dut.dp.dm.core[8]   = 8'h33;
        dut.dp.dm.core[191] = 8'h5A;
        dut.dp.dm.core[195] = 8'hA5;
        repeat (3) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++)
            check($sformatf("rst_rf%0d", i), 32'(dut.dp.rf.registers[i]), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run("zeros_p0",   5'b00000, 8'h00, 8'h00, 8'h00, 128, 32, 252, -1);
        run("zeros_p1f",  5'b11111, 8'h00, 8'h00, 8'h00,   0,  0,   0, -1);
        run("alt55",      5'b10101, 8'h55, 8'h55, 8'h55,  64, 32, 126, -1);
        run("ff_tail",    5'b00000, 8'h00, 8'hFF, 8'hFF,   4,  1,   4, -1);
        run("cross_only", 5'b11111, 8'h0F, 8'hF0, 8'h00,   0,  0,   4, -1);
        run("pulse_scan", 5'b10101, 8'h55, 8'h55, 8'h55,  64, 32, 126, 5);
        repeat (10) @(negedge clk);
        check("pulse_no_restart", 32'(done), 32'd1);

        // Abort a run mid-scan; previously written results must survive.
        dut.dp.dm.core[192] = 8'hAA;
        dut.dp.dm.core[193] = 8'hBB;
        dut.dp.dm.core[194] = 8'hCC;
        @(negedge clk) start = 1'b1;
        load_data(5'b00000, 8'h00, 8'h00, 8'h00);
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("abort_done", 32'(done), 32'd0);
        check("abort_a", 32'(dut.dp.dm.core[192]), 32'hAA);
        check("abort_b", 32'(dut.dp.dm.core[193]), 32'hBB);
        check("abort_c", 32'(dut.dp.dm.core[194]), 32'hCC);
        for (int i = 0; i < 4; i++)
            check($sformatf("abort_rf%0d", i), 32'(dut.dp.rf.registers[i]), 32'd0);
        repeat (50) @(negedge clk);
        check("abort_idle", 32'(done), 32'd0);
        check("abort_keep_c", 32'(dut.dp.dm.core[194]), 32'hCC);
        run("after_abort", 5'b00000, 8'h00, 8'hFF, 8'hFF, 4, 1, 4, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
